ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage MIPS-style pipeline.
//
// Computes logic, shift, arithmetic and link results combinationally, and
// runs a multi-cycle restoring divider (DIV / DIVU) that stalls the front of
// the pipeline while it works.
//
// Ports
//   clk                 in   pipeline clock, rising edge
//   rst                 in   synchronous active-high reset
//   reg1_i / reg2_i     in   operands A / B from ID/EX
//   aluop_i             in   operation code
//   alusel_i            in   result class
//   we_i / waddr_i      in   GPR write enable / destination
//   link_addr_i         in   return address for link instructions
//   is_in_delayslot_i   in   delay-slot flag
//   flush_i             in   abort an in-flight division
//   wdata_o/we_o/waddr_o out GPR write-back towards EX/MEM
//   whilo_o/hi_o/lo_o   out  HI/LO write (remainder / quotient)
//   stallreq_o          out  stall request for IF..EX
//   is_in_delayslot_o   out  delay-slot flag pass-through
// ---------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] link_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic        flush_i,
    output logic [31:0] wdata_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o,
    output logic        is_in_delayslot_o
);

    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;
    localparam logic [2:0] SEL_JUMP  = 3'd4;
    localparam logic [2:0] SEL_DIV   = 3'd5;

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h04;
    localparam logic [7:0] OP_SRL  = 8'h06;
    localparam logic [7:0] OP_SRA  = 8'h07;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    div_state_t  state_r;
    div_state_t  state_nxt_s;
    logic [5:0]  cnt_r;
    logic [31:0] quo_r;       // holds |dividend| at start, quotient at the end
    logic [31:0] rem_r;
    logic [31:0] dvsr_r;
    logic        neg_q_r;
    logic        neg_rem_r;

    logic        div_sel_s;
    logic        div_signed_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        ge_s;
    logic [31:0] alu_res_s;
    logic [4:0]  sh_s;

    assign div_sel_s    = (alusel_i == SEL_DIV);
    assign div_signed_s = (aluop_i == OP_DIV);
    assign a_neg_s      = div_signed_s & reg1_i[31];
    assign b_neg_s      = div_signed_s & reg2_i[31];
    assign abs_a_s      = a_neg_s ? (32'd0 - reg1_i) : reg1_i;
    assign abs_b_s      = b_neg_s ? (32'd0 - reg2_i) : reg2_i;
    assign sh_s         = reg1_i[4:0];

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // The partial remainder is always below the divisor, so 33 bits suffice.
    assign shifted_s = {rem_r, quo_r[31]};
    assign diff_s    = shifted_s - {1'b0, dvsr_r};
    assign ge_s      = (shifted_s >= {1'b0, dvsr_r});

    // Combinational result for all single-cycle classes.
    always_comb begin
        alu_res_s = 32'd0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  alu_res_s = reg1_i & reg2_i;
                    OP_OR:   alu_res_s = reg1_i | reg2_i;
                    OP_XOR:  alu_res_s = reg1_i ^ reg2_i;
                    OP_NOR:  alu_res_s = ~(reg1_i | reg2_i);
                    default: alu_res_s = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  alu_res_s = reg2_i << sh_s;
                    OP_SRL:  alu_res_s = reg2_i >> sh_s;
                    OP_SRA:  alu_res_s = $unsigned($signed(reg2_i) >>> sh_s);
                    default: alu_res_s = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADDU: alu_res_s = reg1_i + reg2_i;
                    OP_SUBU: alu_res_s = reg1_i - reg2_i;
                    OP_SLT:  alu_res_s = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
                    OP_SLTU: alu_res_s = {31'd0, (reg1_i < reg2_i)};
                    default: alu_res_s = 32'd0;
                endcase
            end
            SEL_JUMP: alu_res_s = link_addr_i;
            default:  alu_res_s = 32'd0;
        endcase
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Divider next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (flush_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (div_sel_s) begin
                        state_nxt_s = (reg2_i == 32'd0) ? ST_DONE : ST_BUSY;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: state_nxt_s = (cnt_r == 6'd31) ? ST_DONE : ST_BUSY;
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Divider datapath: operand latch in IDLE, one iteration per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= 6'd0;
            quo_r     <= 32'd0;
            rem_r     <= 32'd0;
            dvsr_r    <= 32'd0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (flush_i) begin
            cnt_r <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 6'd0;
                    if (div_sel_s) begin
                        if (reg2_i == 32'd0) begin
                            quo_r     <= 32'd0;
                            rem_r     <= 32'd0;
                            dvsr_r    <= 32'd0;
                            neg_q_r   <= 1'b0;
                            neg_rem_r <= 1'b0;
                        end else begin
                            quo_r     <= abs_a_s;
                            rem_r     <= 32'd0;
                            dvsr_r    <= abs_b_s;
                            neg_q_r   <= a_neg_s ^ b_neg_s;
                            neg_rem_r <= a_neg_s;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r + 6'd1;
                    quo_r <= {quo_r[30:0], ge_s};
                    rem_r <= ge_s ? diff_s[31:0] : shifted_s[31:0];
                end
                default: cnt_r <= 6'd0;
            endcase
        end
    end

    // Output decode; everything is held at zero while rst is high.
    always_comb begin
        wdata_o           = 32'd0;
        we_o              = 1'b0;
        waddr_o           = 5'd0;
        whilo_o           = 1'b0;
        hi_o              = 32'd0;
        lo_o              = 32'd0;
        stallreq_o        = 1'b0;
        is_in_delayslot_o = 1'b0;
        if (rst) begin
            wdata_o = 32'd0;
        end else begin
            waddr_o           = waddr_i;
            is_in_delayslot_o = is_in_delayslot_i;
            if (div_sel_s) begin
                we_o    = 1'b0;
                wdata_o = 32'd0;
            end else begin
                we_o    = we_i;
                wdata_o = alu_res_s;
            end
            if (flush_i) begin
                stallreq_o = 1'b0;
                whilo_o    = 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: stallreq_o = div_sel_s;
                    ST_BUSY: stallreq_o = 1'b1;
                    ST_DONE: begin
                        whilo_o = 1'b1;
                        lo_o    = neg_q_r   ? (32'd0 - quo_r) : quo_r;
                        hi_o    = neg_rem_r ? (32'd0 - rem_r) : rem_r;
                    end
                    default: stallreq_o = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- directed self-checking bench for ex_stage.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] link_addr_i;
    logic        is_in_delayslot_i;
    logic        flush_i;
    logic [31:0] wdata_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;
    logic        is_in_delayslot_o;

    int assert_cnt;
    int fail_cnt;

    ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .reg1_i            (reg1_i),
        .reg2_i            (reg2_i),
        .aluop_i           (aluop_i),
        .alusel_i          (alusel_i),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .link_addr_i       (link_addr_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .flush_i           (flush_i),
        .wdata_o           (wdata_o),
        .we_o              (we_o),
        .waddr_o           (waddr_o),
        .whilo_o           (whilo_o),
        .hi_o              (hi_o),
        .lo_o              (lo_o),
        .stallreq_o        (stallreq_o),
        .is_in_delayslot_o (is_in_delayslot_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alusel_i = sel;
        aluop_i  = op;
        reg1_i   = a;
        reg2_i   = b;
        we_i     = 1'b1;
        waddr_i  = 5'd9;
    endtask

    // Drive one single-cycle op and check the same-cycle result.
    task automatic alu_vec(input string tag, input logic [2:0] sel, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk);
        #1;
        drive(sel, op, a, b);
        @(negedge clk);
        check_value(tag, wdata_o, exp);
    endtask

    // Run a division, count stall cycles, then check the HI/LO pulse.
    task automatic div_vec(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        @(posedge clk);
        #1;
        drive(3'd5, op, a, b);
        n = 0;
        @(negedge clk);
        check_value({tag, "_we"}, {31'd0, we_o}, 32'd0);
        check_value({tag, "_wdata"}, wdata_o, 32'd0);
        while (stallreq_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_value({tag, "_stalls"}, n, exp_stall);
        check_value({tag, "_whilo"}, {31'd0, whilo_o}, 32'd1);
        check_value({tag, "_lo"}, lo_o, exp_lo);
        check_value({tag, "_hi"}, hi_o, exp_hi);
        @(posedge clk);
        #1;
        drive(3'd0, 8'h00, 32'd0, 32'd0);
        @(negedge clk);
        check_value({tag, "_idle_stall"}, {31'd0, stallreq_o}, 32'd0);
        check_value({tag, "_idle_whilo"}, {31'd0, whilo_o}, 32'd0);
    endtask

    // Watch for a stray HI/LO pulse over a window.
    task automatic no_pulse(input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (whilo_o) pulses++;
        end
        check_value(tag, pulses, 32'd0);
    endtask

    initial begin
        assert_cnt        = 0;
        fail_cnt          = 0;
        rst               = 1'b1;
        flush_i           = 1'b0;
        link_addr_i       = 32'h0040_0108;
        is_in_delayslot_i = 1'b1;
        drive(3'd3, 8'h21, 32'h1234_0000, 32'h0000_5678);

        // Reset: all outputs held at zero.
        @(negedge clk);
        @(negedge clk);
        check_value("rst_wdata", wdata_o, 32'd0);
        check_value("rst_we", {31'd0, we_o}, 32'd0);
        check_value("rst_stall", {31'd0, stallreq_o}, 32'd0);
        check_value("rst_dslot", {31'd0, is_in_delayslot_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-cycle ops.
        alu_vec("addu_wrap", 3'd3, 8'h21, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        check_value("addu_we", {31'd0, we_o}, 32'd1);
        check_value("addu_waddr", {27'd0, waddr_o}, 32'd9);
        check_value("addu_stall", {31'd0, stallreq_o}, 32'd0);
        check_value("addu_whilo", {31'd0, whilo_o}, 32'd0);
        check_value("dslot_pass", {31'd0, is_in_delayslot_o}, 32'd1);
        alu_vec("subu", 3'd3, 8'h23, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        alu_vec("slt", 3'd3, 8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        alu_vec("sltu", 3'd3, 8'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        alu_vec("and", 3'd1, 8'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu_vec("or", 3'd1, 8'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        alu_vec("xor", 3'd1, 8'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu_vec("nor", 3'd1, 8'h27, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
        alu_vec("sll", 3'd2, 8'h04, 32'h0000_003F, 32'h0000_0001, 32'h8000_0000);
        alu_vec("srl", 3'd2, 8'h06, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000);
        alu_vec("sra", 3'd2, 8'h07, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000);
        alu_vec("jump", 3'd4, 8'h00, 32'h1111_1111, 32'h2222_2222, 32'h0040_0108);
        alu_vec("bad_op", 3'd1, 8'h99, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        alu_vec("bad_sel", 3'd7, 8'h21, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);

        // Divisions.
        div_vec("div_neg", 8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        div_vec("div_negb", 8'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'h0000_0001);
        div_vec("divu", 8'h1B, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0FFF_FFFF, 32'h0000_000F);
        div_vec("div_zero", 8'h1A, 32'h0000_1234, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0000);

        // Flush at BUSY counter 10 (12th stall cycle).
        @(posedge clk);
        #1;
        drive(3'd5, 8'h1A, 32'h0000_0064, 32'h0000_0007);
        repeat (11) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check_value("flush_stall", {31'd0, stallreq_o}, 32'd0);
        check_value("flush_whilo", {31'd0, whilo_o}, 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        drive(3'd3, 8'h21, 32'h0000_0003, 32'h0000_0004);
        @(negedge clk);
        check_value("flush_addu", wdata_o, 32'h0000_0007);
        check_value("flush_after_stall", {31'd0, stallreq_o}, 32'd0);
        no_pulse("flush_no_pulse");

        // Reset at BUSY counter 20 (22nd stall cycle).
        @(posedge clk);
        #1;
        drive(3'd5, 8'h1B, 32'h0000_0064, 32'h0000_0007);
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_value("rst_mid_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3'd3, 8'h21, 32'h0000_0010, 32'h0000_0020);
        @(negedge clk);
        check_value("rst_addu", wdata_o, 32'h0000_0030);
        check_value("rst_after_stall", {31'd0, stallreq_o}, 32'd0);
        no_pulse("rst_no_pulse");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
